// File: rtl/pixie_pkg.sv
// pixie_pkg: frame geometry shared by the Pixie front and back ends, plus the DMA FSM states
package pixie_pkg;
  localparam int FB_MCYCLES = 14;
  localparam int FB_LINES = 262;
  localparam int FB_FIRST_ACTIVE = 64;
  localparam int FB_ROWS = 128;
  localparam int FB_BYTES = 8;
  localparam int ROW_W = 7;
  localparam int BYTE_W = 3;
  localparam int ADDR_W = ROW_W + BYTE_W;
  localparam int MC_W = 4;
  localparam int LINE_W = 9;
  typedef enum logic [1:0] {DMA_IDLE, DMA_REQ, DMA_DONE} dma_state_e;
  function automatic logic in_range(input logic [LINE_W-1:0] v, input int lo, input int hi);
    return (v >= LINE_W'(lo)) && (v < LINE_W'(hi));
  endfunction
endpackage

// File: rtl/pixie_mc_line_counter.sv
// pixie_mc_line_counter: machine-cycle and scan-line counters with a line_wrap strobe
module pixie_mc_line_counter
  import pixie_pkg::*;
#(
  parameter int MCYCLES_PER_LINE = FB_MCYCLES,
  parameter int LINES_PER_FRAME = FB_LINES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_ce,
  output logic [MC_W-1:0]   mc,
  output logic [LINE_W-1:0] line,
  output logic              line_wrap
);
  logic [MC_W-1:0] mc_q, mc_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic mc_last, line_last;
  always_comb begin
    mc_last = mc_q == MC_W'(MCYCLES_PER_LINE - 1);
    line_last = line_q == LINE_W'(LINES_PER_FRAME - 1);
    line_wrap = cpu_ce & mc_last;
    mc_d = !cpu_ce ? mc_q : mc_last ? '0 : mc_q + MC_W'(1);
    line_d = !line_wrap ? line_q : line_last ? '0 : line_q + LINE_W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_q <= '0;
      line_q <= '0;
    end else begin
      mc_q <= mc_d;
      line_q <= line_d;
    end
  end
  assign mc = mc_q;
  assign line = line_q;
endmodule

// File: rtl/pixie_dp_front_end.sv
// pixie_dp_front_end: CDP1861-style frame timing, INT/EF flags and DMA-out capture into the frame buffer
module pixie_dp_front_end
  import pixie_pkg::*;
#(
  parameter int MCYCLES_PER_LINE = FB_MCYCLES,
  parameter int LINES_PER_FRAME = FB_LINES,
  parameter int FIRST_ACTIVE_LINE = FB_FIRST_ACTIVE,
  parameter int ACTIVE_LINES = FB_ROWS,
  parameter int BYTES_PER_LINE = FB_BYTES,
  parameter int DMA_START_MC = 2,
  parameter int INT_LEAD_LINES = 2,
  parameter int EF_LEAD_LINES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_ce,
  input  logic              disp_on,
  input  logic              disp_off,
  input  logic              dma_ack,
  input  logic [7:0]        data_in,
  output logic              dma_req,
  output logic              int_req,
  output logic              efx,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              disp_en
);
  localparam int LAST_END = FIRST_ACTIVE_LINE + ACTIVE_LINES;
  logic [MC_W-1:0] mc;
  logic [LINE_W-1:0] line, row_full;
  logic line_wrap, active, start, capture, last_byte;
  dma_state_e state_q, state_d;
  logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
  logic disp_en_q, disp_en_d, dma_req_q, dma_req_d, int_req_q, int_req_d, efx_q, efx_d;
  logic fb_wr_en_q, fb_wr_en_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [7:0] fb_data_q, fb_data_d;

  pixie_mc_line_counter #(
    .MCYCLES_PER_LINE(MCYCLES_PER_LINE),
    .LINES_PER_FRAME(LINES_PER_FRAME)
  ) u_cnt (
    .clk(clk),
    .reset(reset),
    .cpu_ce(cpu_ce),
    .mc(mc),
    .line(line),
    .line_wrap(line_wrap)
  );

  always_comb begin
    disp_en_d = disp_off ? 1'b0 : disp_on ? 1'b1 : disp_en_q;
    active = in_range(line, FIRST_ACTIVE_LINE, LAST_END);
    row_full = line - LINE_W'(FIRST_ACTIVE_LINE);
    start = cpu_ce & (mc == MC_W'(DMA_START_MC)) & active & disp_en_q & disp_en_d;
    capture = (state_q == DMA_REQ) & dma_ack & cpu_ce;
    last_byte = byte_idx_q == BYTE_W'(BYTES_PER_LINE - 1);
    state_d = (state_q == DMA_IDLE) ? (start ? DMA_REQ : DMA_IDLE)
            : (state_q == DMA_REQ) ? ((line_wrap | !disp_en_d) ? DMA_IDLE : (capture & last_byte) ? DMA_DONE : DMA_REQ)
            : (line_wrap ? DMA_IDLE : DMA_DONE);
    byte_idx_d = (state_q == DMA_IDLE) ? '0 : capture ? byte_idx_q + BYTE_W'(1) : byte_idx_q;
    dma_req_d = state_d == DMA_REQ;
    int_req_d = disp_en_q & in_range(line, FIRST_ACTIVE_LINE - INT_LEAD_LINES, FIRST_ACTIVE_LINE);
    efx_d = disp_en_q & (in_range(line, FIRST_ACTIVE_LINE - EF_LEAD_LINES, FIRST_ACTIVE_LINE)
                       | in_range(line, LAST_END - EF_LEAD_LINES, LAST_END));
    fb_wr_en_d = capture;
    fb_addr_d = capture ? {row_full[ROW_W-1:0], byte_idx_q} : fb_addr_q;
    fb_data_d = capture ? data_in : fb_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DMA_IDLE;
      byte_idx_q <= '0;
      disp_en_q <= 1'b0;
      dma_req_q <= 1'b0;
      int_req_q <= 1'b0;
      efx_q <= 1'b0;
      fb_wr_en_q <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      state_q <= state_d;
      byte_idx_q <= byte_idx_d;
      disp_en_q <= disp_en_d;
      dma_req_q <= dma_req_d;
      int_req_q <= int_req_d;
      efx_q <= efx_d;
      fb_wr_en_q <= fb_wr_en_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign dma_req = dma_req_q;
  assign int_req = int_req_q;
  assign efx = efx_q;
  assign fb_wr_en = fb_wr_en_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;
  assign disp_en = disp_en_q;
endmodule

// File: tb/tb_pixie_dp_front_end.sv
// tb_pixie_dp_front_end: scoreboard bench with a line/frame-level reference model of the Pixie front end
module tb_pixie_dp_front_end;
  logic clk = 1'b0, reset = 1'b1, cpu_ce = 1'b0, disp_on = 1'b0, disp_off = 1'b0, dma_ack = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic dma_req, int_req, efx, fb_wr_en, disp_en;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;

  pixie_dp_front_end dut (
    .clk(clk),
    .reset(reset),
    .cpu_ce(cpu_ce),
    .disp_on(disp_on),
    .disp_off(disp_off),
    .dma_ack(dma_ack),
    .data_in(data_in),
    .dma_req(dma_req),
    .int_req(int_req),
    .efx(efx),
    .fb_wr_en(fb_wr_en),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .disp_en(disp_en)
  );

  always #5 clk = ~clk;

  typedef struct {bit dma_req; bit int_req; bit efx; bit disp_en; bit zero_bus;} st_t;
  typedef struct {int addr; int data;} wr_t;
  st_t st_q[$];
  wr_t wr_q[$];
  int checks = 0, errors = 0;
  bit done = 1'b0, fin = 1'b0;

  int m_mc = 0, m_line = 0, m_cnt = 0;
  bit m_en = 1'b0, m_req = 1'b0, m_done = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  st_t e;
  wr_t w;
  always @(negedge clk) begin
    if (!fin) begin
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("dma_req", int'(dma_req), int'(e.dma_req));
        chk("int_req", int'(int_req), int'(e.int_req));
        chk("efx", int'(efx), int'(e.efx));
        chk("disp_en", int'(disp_en), int'(e.disp_en));
        if (e.zero_bus) begin
          chk("fb_addr_rst", int'(fb_addr), 0);
          chk("fb_data_rst", int'(fb_data), 0);
        end
      end
      if (fb_wr_en) begin
        if (wr_q.size() == 0) chk("fb_wr_en_spurious", int'(fb_wr_en), 0);
        else begin
          w = wr_q.pop_front();
          chk("fb_addr", int'(fb_addr), w.addr);
          chk("fb_data", int'(fb_data), w.data);
        end
      end else if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        chk("fb_wr_en_missing", int'(fb_wr_en), 1);
      end
      if (done) begin
        chk("wr_q_drained", wr_q.size(), 0);
        chk("st_q_drained", st_q.size(), 0);
        fin = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  task automatic step(int ce, int on, int off, int ack, int d, int rst);
    st_t s;
    wr_t nw;
    bit en_nx, wr, wrap, start, act;
    @(negedge clk);
    cpu_ce = (ce != 0);
    disp_on = (on != 0);
    disp_off = (off != 0);
    dma_ack = (ack != 0);
    data_in = 8'(d);
    reset = (rst != 0);
    wr = 1'b0;
    if (rst != 0) begin
      s = '{0, 0, 0, 0, 1};
      m_mc = 0; m_line = 0; m_cnt = 0; m_en = 0; m_req = 0; m_done = 0;
    end else begin
      en_nx = (off != 0) ? 1'b0 : (on != 0) ? 1'b1 : m_en;
      act = m_line >= 64 && m_line < 192;
      s.int_req = m_en && m_line >= 62 && m_line < 64;
      s.efx = m_en && ((m_line >= 60 && m_line < 64) || (m_line >= 188 && m_line < 192));
      s.zero_bus = 1'b0;
      wr = m_req && ack != 0 && ce != 0;
      if (wr) begin
        nw.addr = (m_line - 64) * 8 + m_cnt;
        nw.data = d & 8'hFF;
        m_cnt++;
      end
      wrap = ce != 0 && m_mc == 13;
      start = !m_req && !m_done && ce != 0 && m_mc == 2 && act && m_en && en_nx;
      if (m_req) begin
        if (wrap || !en_nx) m_req = 1'b0;
        else if (m_cnt == 8) begin
          m_req = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_req = 1'b1;
        m_cnt = 0;
      end
      if (wrap) m_done = 1'b0;
      if (ce != 0) begin
        m_mc = (m_mc + 1) % 14;
        if (m_mc == 0) m_line = (m_line + 1) % 262;
      end
      m_en = en_nx;
      s.dma_req = m_req;
      s.disp_en = m_en;
    end
    @(posedge clk);
    #1;
    st_q.push_back(s);
    if (wr) wr_q.push_back(nw);
  endtask

  task automatic run_to(int l, int mc);
    for (int i = 0; i < 4000 && !(m_line == l && m_mc == mc); i++) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic acks(int n, int base);
    for (int i = 0; i < n; i++) step(1, 0, 0, 1, base + 17 * i, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    step(1, 0, 0, 1, 8'hAA, 1);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3700; i++) step(1, 0, 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    run_to(64, 3);
    acks(8, 8'h11);
    run_to(70, 3);
    acks(3, 8'h31);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 8'h5A, 0);
    step(1, 1, 0, 0, 0, 0);
    run_to(80, 3);
    acks(5, 8'h41);
    run_to(81, 3);
    acks(8, 8'h02);
    run_to(191, 3);
    acks(8, 8'h07);
    run_to(192, 0);
    for (int i = 0; i < 14; i++) step(1, 0, 0, 1, i, 0);
    run_to(100, 7);
    step(1, 0, 0, 1, 8'hEE, 1);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 1, i, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6000; i++)
      step(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 299) == 0), int'($urandom_range(0, 399) == 0),
           int'($urandom_range(0, 2) != 0), int'($urandom_range(0, 255)), 0);
    step(0, 0, 0, 0, 0, 0);
    done = 1'b1;
  end
endmodule
